// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: port ids and priority encodings shared by the arbiter slice
package mem_port_arbiter_pkg;
  localparam logic PORT_IFU = 1'b0;
  localparam logic PORT_LSU = 1'b1;
  localparam int PRIO_RR = 0;
  localparam int PRIO_FIXED = 1;
endpackage

// File: rtl/mem_rsp_buf.sv
// mem_rsp_buf: one-entry response holding register with zero-latency bypass
module mem_rsp_buf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  byp_valid,
  input  logic [DATA_WIDTH-1:0] byp_data,
  input  logic                  rsp_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  buf_vld
);
  logic                  buf_vld_q;
  logic [DATA_WIDTH-1:0] buf_data_q;
  // the macro clears its output when idle, so a stalled response must be captured here
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      buf_vld_q  <= 1'b0;
      buf_data_q <= '0;
    end else if (byp_valid && !rsp_ready) begin
      buf_vld_q  <= 1'b1;
      buf_data_q <= byp_data;
    end else if (rsp_ready) begin
      buf_vld_q  <= 1'b0;
    end
  end
  always_comb begin
    rsp_valid = buf_vld_q | byp_valid;
    rsp_rdata = buf_vld_q ? buf_data_q : byp_valid ? byp_data : '0;
    buf_vld   = buf_vld_q;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-port arbiter/sequencer in front of a single-port registered-read memory
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIXED_PRIO = PRIO_RR
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  mem_ena,
  output logic                  mem_wea,
  output logic [ADDR_WIDTH-1:0] mem_addra,
  output logic [DATA_WIDTH-1:0] mem_dina,
  input  logic [DATA_WIDTH-1:0] mem_douta
);
  logic       inflight_q, inflight_id_q, last_grant_q;
  logic       gnt, gnt_id;
  logic [1:0] elig, byp, buf_vld;
  // a port whose last response will be buffered next cycle must not issue again
  always_comb begin
    byp[0]  = inflight_q & (inflight_id_q == PORT_IFU);
    byp[1]  = inflight_q & (inflight_id_q == PORT_LSU);
    elig[0] = req0_valid & ~buf_vld[0] & ~(byp[0] & ~rsp0_ready);
    elig[1] = req1_valid & ~buf_vld[1] & ~(byp[1] & ~rsp1_ready);
    gnt     = ~rsta & |elig;
    gnt_id  = &elig ? (FIXED_PRIO == PRIO_FIXED ? PORT_IFU : ~last_grant_q) : elig[1];
    req0_ready = gnt & (gnt_id == PORT_IFU);
    req1_ready = gnt & (gnt_id == PORT_LSU);
    mem_ena    = gnt;
    mem_wea    = gnt & (gnt_id ? req1_we : req0_we);
    mem_addra  = gnt ? (gnt_id ? req1_addr : req0_addr) : '0;
    mem_dina   = gnt ? (gnt_id ? req1_wdata : req0_wdata) : '0;
  end
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      inflight_q    <= 1'b0;
      inflight_id_q <= PORT_IFU;
      last_grant_q  <= PORT_LSU;
    end else begin
      inflight_q <= gnt;
      if (gnt) begin
        inflight_id_q <= gnt_id;
        last_grant_q  <= gnt_id;
      end
    end
  end
  mem_rsp_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf0 (
    .clka(clka), .rsta(rsta), .byp_valid(byp[0]), .byp_data(mem_douta),
    .rsp_ready(rsp0_ready), .rsp_valid(rsp0_valid), .rsp_rdata(rsp0_rdata), .buf_vld(buf_vld[0])
  );
  mem_rsp_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf1 (
    .clka(clka), .rsta(rsta), .byp_valid(byp[1]), .byp_data(mem_douta),
    .rsp_ready(rsp1_ready), .rsp_valid(rsp1_valid), .rsp_rdata(rsp1_rdata), .buf_vld(buf_vld[1])
  );
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a registered-read memory model
module tb_mem_port_arbiter;
  logic        clka = 1'b0, rsta;
  logic        req0_valid, req0_ready, req0_we, rsp0_valid, rsp0_ready;
  logic        req1_valid, req1_ready, req1_we, rsp1_valid, rsp1_ready;
  logic [31:0] req0_addr, req0_wdata, rsp0_rdata, req1_addr, req1_wdata, rsp1_rdata;
  logic        mem_ena, mem_wea;
  logic [31:0] mem_addra, mem_dina, mem_douta;
  logic        f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid, f_mem_ena, f_mem_wea;
  logic [31:0] f_rsp0_rdata, f_rsp1_rdata, f_mem_addra, f_mem_dina;
  logic [31:0] f_douta = '0;
  logic [31:0] mem [256];
  logic [31:0] exp0[$], exp1[$];
  int checks = 0, errors = 0, n_rsp0 = 0, n_rsp1 = 0, f_g0 = 0, f_g1 = 0;
  logic win = 1'b0;

  always #5 clka = ~clka;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIO(0)) u_dut (
    .clka(clka), .rsta(rsta),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rdata(rsp1_rdata),
    .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addra(mem_addra), .mem_dina(mem_dina), .mem_douta(mem_douta)
  );

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIO(1)) u_fix (
    .clka(clka), .rsta(rsta),
    .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .rsp0_valid(f_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rdata(f_rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .rsp1_valid(f_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rdata(f_rsp1_rdata),
    .mem_ena(f_mem_ena), .mem_wea(f_mem_wea), .mem_addra(f_mem_addra), .mem_dina(f_mem_dina), .mem_douta(f_douta)
  );

  // write-first macro model; output clears whenever the macro is not enabled
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
    mem[8'h10] = 32'hDEAD_BEEF;
  end
  always @(posedge clka) begin
    if (mem_ena) begin
      if (mem_wea) mem[mem_addra[7:0]] <= mem_dina;
      mem_douta <= mem_wea ? mem_dina : mem[mem_addra[7:0]];
    end else begin
      mem_douta <= '0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clka) begin
    if (!rsta && rsp0_valid && rsp0_ready) begin
      n_rsp0++;
      if (exp0.size() == 0) chk("rsp0_unexpected", rsp0_rdata, 32'hxxxx_xxxx);
      else chk("rsp0_data", rsp0_rdata, exp0.pop_front());
    end
    if (!rsta && rsp1_valid && rsp1_ready) begin
      n_rsp1++;
      if (exp1.size() == 0) chk("rsp1_unexpected", rsp1_rdata, 32'hxxxx_xxxx);
      else chk("rsp1_data", rsp1_rdata, exp1.pop_front());
    end
    if (win) begin
      f_g0 += int'(f_req0_ready);
      f_g1 += int'(f_req1_ready);
    end
  end

  task automatic tick();
    @(posedge clka);
    #1;
  endtask
  task automatic set0(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
    req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
  endtask
  task automatic set1(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
    req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
  endtask

  initial begin
    int a0, a1, n0, n1;
    rsta = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    set0(1, 0, 32'h10, 0); set1(0, 0, 0, 0);
    repeat (2) @(posedge clka);
    #1;
    chk("rst_req0_ready", 32'(req0_ready), 0);
    chk("rst_mem_ena", 32'(mem_ena), 0);
    chk("rst_mem_addra", mem_addra, 0);
    chk("rst_rsp0_valid", 32'(rsp0_valid), 0);
    set0(0, 0, 0, 0);
    rsta = 1'b0;
    tick();
    // single read
    set0(1, 0, 32'h10, 0); exp0.push_back(32'hDEAD_BEEF);
    @(negedge clka);
    chk("rd_req0_ready", 32'(req0_ready), 1);
    chk("rd_mem_ena", 32'(mem_ena), 1);
    chk("rd_mem_addra", mem_addra, 32'h10);
    chk("rd_req1_ready", 32'(req1_ready), 0);
    tick();
    set0(0, 0, 0, 0);
    @(negedge clka);
    chk("rd_rsp0_valid", 32'(rsp0_valid), 1);
    tick();
    // write then read on port 1
    set1(1, 1, 32'h20, 32'hCAFE_F00D); exp1.push_back(32'hCAFE_F00D);
    @(negedge clka);
    chk("wr_req1_ready", 32'(req1_ready), 1);
    chk("wr_mem_wea", 32'(mem_wea), 1);
    chk("wr_mem_dina", mem_dina, 32'hCAFE_F00D);
    tick();
    set1(1, 0, 32'h20, 0); exp1.push_back(32'hCAFE_F00D);
    @(negedge clka);
    chk("wr_rsp1_valid", 32'(rsp1_valid), 1);
    chk("rd1_req1_ready", 32'(req1_ready), 1);
    tick();
    set1(0, 0, 0, 0);
    @(negedge clka);
    chk("rd1_rsp1_valid", 32'(rsp1_valid), 1);
    chk("idle_mem_ena", 32'(mem_ena), 0);
    chk("idle_mem_addra", mem_addra, 0);
    chk("idle_rsp0_rdata", rsp0_rdata, 0);
    tick();
    // contention: round-robin alternates, fixed priority starves port 1
    a0 = 0; a1 = 1; n0 = n_rsp0; n1 = n_rsp1; win = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set0(1, 0, a0, 0); set1(1, 0, a1, 0);
      @(negedge clka);
      chk($sformatf("rr_gnt0_%0d", i), 32'(req0_ready), 32'(i % 2 == 0));
      chk($sformatf("rr_gnt1_%0d", i), 32'(req1_ready), 32'(i % 2 == 1));
      if (i % 2 == 0) begin exp0.push_back(32'hA500_0000 | a0); a0 += 2; end
      else begin exp1.push_back(32'hA500_0000 | a1); a1 += 2; end
      tick();
    end
    win = 1'b0;
    set0(0, 0, 0, 0); set1(0, 0, 0, 0);
    @(negedge clka);
    tick();
    chk("rr_rsp0_count", n_rsp0 - n0, 3);
    chk("rr_rsp1_count", n_rsp1 - n1, 3);
    chk("fix_gnt0_count", f_g0, 6);
    chk("fix_gnt1_count", f_g1, 0);
    // backpressure on port 0 while port 1 keeps streaming
    rsp0_ready = 1'b0;
    set0(1, 0, 32'h10, 0); set1(1, 0, 32'h30, 0); exp0.push_back(32'hDEAD_BEEF);
    @(negedge clka);
    chk("bp_gnt0", 32'(req0_ready), 1);
    chk("bp_nognt1", 32'(req1_ready), 0);
    tick();
    set0(0, 0, 0, 0); exp1.push_back(32'hA500_0030);
    @(negedge clka);
    chk("bp_rsp0_valid_a", 32'(rsp0_valid), 1);
    chk("bp_rsp0_data_a", rsp0_rdata, 32'hDEAD_BEEF);
    chk("bp_gnt1_a", 32'(req1_ready), 1);
    tick();
    set0(1, 0, 32'h11, 0); set1(1, 0, 32'h31, 0); exp1.push_back(32'hA500_0031);
    @(negedge clka);
    chk("bp_rsp0_data_b", rsp0_rdata, 32'hDEAD_BEEF);
    chk("bp_stall0_b", 32'(req0_ready), 0);
    chk("bp_gnt1_b", 32'(req1_ready), 1);
    tick();
    set1(0, 0, 0, 0);
    @(negedge clka);
    chk("bp_rsp0_data_c", rsp0_rdata, 32'hDEAD_BEEF);
    chk("bp_stall0_c", 32'(req0_ready), 0);
    chk("bp_mem_ena_c", 32'(mem_ena), 0);
    tick();
    rsp0_ready = 1'b1;
    @(negedge clka);
    chk("bp_douta_cleared", mem_douta, 0);
    chk("bp_rsp0_data_d", rsp0_rdata, 32'hDEAD_BEEF);
    chk("bp_clear_nognt0", 32'(req0_ready), 0);
    tick();
    exp0.push_back(32'hA500_0011);
    @(negedge clka);
    chk("bp_regrant0", 32'(req0_ready), 1);
    tick();
    set0(0, 0, 0, 0);
    @(negedge clka);
    tick();
    // reset in the response cycle of a port 1 read
    set1(1, 0, 32'h40, 0);
    @(negedge clka);
    chk("mr_gnt1", 32'(req1_ready), 1);
    tick();
    rsta = 1'b1;
    set0(1, 0, 32'h50, 0); set1(1, 0, 32'h51, 0);
    #1;
    chk("mr_rsp1_valid", 32'(rsp1_valid), 0);
    chk("mr_rsp1_rdata", rsp1_rdata, 0);
    chk("mr_mem_ena", 32'(mem_ena), 0);
    chk("mr_req0_ready", 32'(req0_ready), 0);
    chk("mr_req1_ready", 32'(req1_ready), 0);
    tick();
    tick();
    rsta = 1'b0; exp0.push_back(32'hA500_0050);
    @(negedge clka);
    chk("mr_tie_gnt0", 32'(req0_ready), 1);
    chk("mr_tie_nognt1", 32'(req1_ready), 0);
    tick();
    set0(0, 0, 0, 0); exp1.push_back(32'hA500_0051);
    @(negedge clka);
    chk("mr_gnt1_after", 32'(req1_ready), 1);
    tick();
    set1(0, 0, 0, 0);
    @(negedge clka);
    tick();
    // back-to-back streaming on port 0
    n0 = n_rsp0;
    for (int i = 0; i < 8; i++) begin
      set0(1, 0, i, 0); exp0.push_back(32'hA500_0000 | i);
      @(negedge clka);
      chk($sformatf("st_gnt_%0d", i), 32'(req0_ready), 1);
      if (i > 0) chk($sformatf("st_rsp_%0d", i), 32'(rsp0_valid), 1);
      tick();
    end
    set0(0, 0, 0, 0);
    @(negedge clka);
    chk("st_rsp_last", 32'(rsp0_valid), 1);
    tick();
    @(negedge clka);
    chk("st_idle", 32'(rsp0_valid), 0);
    chk("st_count", n_rsp0 - n0, 8);
    chk("q0_drained", exp0.size(), 0);
    chk("q1_drained", exp1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
